// File: rtl/fetch_align_buffer.sv
// ============================================================================
// fetch_align_buffer -- halfword-granular fetch buffer feeding the RVC expander.
// Optional macro FETCH_ALIGN_ILLEGAL_CHECK_EN adds inst_illegal_o. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_align_buffer #(
  parameter int              DEPTH_HW = 8,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [PC_W-1:0]            flush_pc_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [31:0]                fetch_data_i,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [31:0]                inst_o,
  output logic [PC_W-1:0]            inst_pc_o,
  output logic                       inst_is_comp_o,
  output logic [$clog2(DEPTH_HW):0]  count_o
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
  ,
  output logic                       inst_illegal_o
`endif
);

  localparam int AW = $clog2(DEPTH_HW);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_PUSH_LIMIT = CW'(DEPTH_HW - 2);

  logic [15:0]     r_mem [DEPTH_HW];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [PC_W-1:0] r_pc;
  logic            r_drop_lo;

  logic [15:0]     w_h0;
  logic [15:0]     w_h1;
  logic            w_comp;
  logic            w_avail;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_push_n;
  logic [CW-1:0]   w_pop_n;
  logic [AW-1:0]   w_wr1;

  assign w_h0   = r_mem[r_rd];
  assign w_h1   = r_mem[r_rd + AW'(1)];
  assign w_comp = (w_h0[1:0] != 2'b11);
  assign w_wr1  = r_wr + AW'(1);

  // A 32-bit instruction needs both halves resident before it is offered.
  assign w_avail = (w_comp && (r_count >= CW'(1))) || (!w_comp && (r_count >= CW'(2)));

  assign fetch_ready_o  = (r_count <= C_PUSH_LIMIT) && !flush_i && !rst;
  assign inst_valid_o   = w_avail && !flush_i && !rst;
  assign inst_o         = w_comp ? {16'h0000, w_h0} : {w_h1, w_h0};
  assign inst_is_comp_o = w_comp;
  assign inst_pc_o      = r_pc;
  assign count_o        = r_count;

`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
  assign inst_illegal_o = inst_valid_o && w_comp && (w_h0 == 16'h0000);
`endif

  assign w_push   = fetch_valid_i && fetch_ready_o;
  assign w_pop    = inst_valid_o && inst_ready_i;
  assign w_push_n = w_push ? (r_drop_lo ? CW'(1) : CW'(2)) : CW'(0);
  assign w_pop_n  = w_pop ? (w_comp ? CW'(1) : CW'(2)) : CW'(0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      if (r_drop_lo) begin
        r_mem[r_wr] <= fetch_data_i[31:16];
      end else begin
        r_mem[r_wr]  <= fetch_data_i[15:0];
        r_mem[w_wr1] <= fetch_data_i[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_pc      <= RESET_PC;
      r_drop_lo <= 1'b0;
    end else if (flush_i) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_pc      <= flush_pc_i & ~PC_W'(1);
      r_drop_lo <= flush_pc_i[1];
    end else begin
      r_count <= r_count + w_push_n - w_pop_n;
      if (w_push) begin
        r_wr      <= r_wr + w_push_n[AW-1:0];
        r_drop_lo <= 1'b0;
      end
      if (w_pop) begin
        r_rd <= r_rd + w_pop_n[AW-1:0];
        r_pc <= r_pc + (w_comp ? PC_W'(2) : PC_W'(4));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_align_buffer.sv
// ============================================================================
// tb_fetch_align_buffer -- randomized scoreboard bench against a halfword-queue
// model of the fetch buffer. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_align_buffer;

  localparam int DEPTH = 8;
  localparam int PW    = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_is_comp_o;
  logic [3:0]  count_o;
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
  logic        inst_illegal_o;
`endif

  fetch_align_buffer #(.DEPTH_HW(DEPTH), .PC_W(PW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_data_i(fetch_data_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_is_comp_o(inst_is_comp_o), .count_o(count_o)
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
    , .inst_illegal_o(inst_illegal_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;
  int n_emitted = 0;

  // Reference model: the buffered halfwords in program order, plus pc and drop flag.
  logic [15:0] mq[$];
  logic [31:0] mpc  = RPC;
  bit          mdrop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs mid-cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (started) begin
      bit e_ready, e_valid, e_comp;
      logic [31:0] e_inst;
      int sz;
      sz      = mq.size();
      e_comp  = (sz >= 1) && (mq[0][1:0] != 2'b11);
      e_valid = !rst && !flush_i && ((sz >= 1 && e_comp) || (sz >= 2 && !e_comp));
      e_ready = !rst && !flush_i && (sz <= DEPTH - 2);
      chk("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, e_ready});
      chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, e_valid});
      chk("count", {28'd0, count_o}, 32'(sz));
      chk("pc", inst_pc_o, mpc);
      if (e_valid) begin
        e_inst = e_comp ? {16'h0000, mq[0]} : {mq[1], mq[0]};
        chk("inst", inst_o, e_inst);
        chk("is_comp", {31'd0, inst_is_comp_o}, {31'd0, e_comp});
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
        chk("illegal", {31'd0, inst_illegal_o}, {31'd0, (e_comp && mq[0] == 16'h0000)});
`endif
      end
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
      else chk("illegal_idle", {31'd0, inst_illegal_o}, 32'd0);
`endif
      if (rst) begin
        mq.delete(); mpc = RPC; mdrop = 1'b0;
      end else if (flush_i) begin
        mq.delete(); mpc = {flush_pc_i[31:1], 1'b0}; mdrop = flush_pc_i[1];
      end else begin
        if (e_valid && inst_ready_i) begin
          n_emitted++;
          if (e_comp) begin void'(mq.pop_front()); mpc += 32'd2; end
          else begin void'(mq.pop_front()); void'(mq.pop_front()); mpc += 32'd4; end
        end
        if (fetch_valid_i && e_ready) begin
          if (!mdrop) mq.push_back(fetch_data_i[15:0]);
          mq.push_back(fetch_data_i[31:16]);
          mdrop = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic rdy,
                     input logic fl, input logic [31:0] fpc);
    fetch_valid_i = v; fetch_data_i = d; inst_ready_i = rdy;
    flush_i = fl; flush_pc_i = fpc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, rdy, 1'b0, 32'h0);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 9) == 0) h = 16'h0000;
    return h;
  endfunction

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;
    idle(2, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    // Two RVC instructions
    cyc(1'b1, 32'h4501_4581, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1);
    // Straddling 32-bit instruction
    cyc(1'b1, 32'h0513_4581, 1'b1, 1'b0, 32'h0);
    idle(2, 1'b1);
    cyc(1'b1, 32'h0001_0050, 1'b1, 1'b0, 32'h0);
    idle(4, 1'b1);
    // Halfword redirect
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
    cyc(1'b1, 32'h4501_FFFF, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1);
    // Fill, then release backpressure while a fifth word is offered
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h4581_4501 + i, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1111_2222, 1'b1, 1'b0, 32'h0);
    idle(10, 1'b1);
    // All-zero halfword followed by an RVC instruction
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    cyc(1'b1, 32'h4581_0000, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1);
    // PC wrap and flush during a fetch
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 32'h0513_4581, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h0001_0050, 1'b1, 1'b0, 32'h0);
    idle(4, 1'b1);
    cyc(1'b1, 32'h4581_4581, 1'b1, 1'b1, 32'h0000_0203);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040);
    cyc(1'b1, 32'h4581_4501, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1);
    // Randomized traffic with occasional flushes and resets
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      fl  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc(1'($urandom_range(0, 3) != 0), {rand_hw(), rand_hw()},
          1'($urandom_range(0, 2) != 0), fl, 32'($urandom));
    end
    rst = 1'b0;
    idle(12, 1'b1);
    total++;
    if (n_emitted < 500) begin
      bad++;
      $display("FAIL emitted_count: got %0d expected at least 500", n_emitted);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Halfword-granular fetch buffer that sits between instruction memory and the compressed-instruction expander/decoder.
- Accepts aligned 32-bit fetch words. Emits one instruction per handshake, either a raw 16-bit RVC instruction (zero-extended) or a full 32-bit instruction, with its PC.
- Handles 32-bit instructions that straddle a fetch-word boundary.
- Handles redirects to halfword-aligned targets, replacing the single-cycle pc[1] mux used previously.

Parameters:
- DEPTH_HW, 8, buffer capacity in halfwords; power of 2, >= 4.
- PC_W, 32, PC width.
- RESET_PC, 32'h0000_0000, PC loaded at reset; bit 0 must be 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  redirect; discard buffer contents.
- flush_pc_i  in  PC_W  redirect target; bit 0 ignored.
- fetch_valid_i  in  1  fetch word valid.
- fetch_ready_o  out  1  buffer can accept a fetch word.
- fetch_data_i  in  32  fetch word; [15:0] is the lower halfword.
- inst_valid_o  out  1  inst_o holds a complete instruction.
- inst_ready_i  in  1  consumer accepts inst_o.
- inst_o  out  32  instruction; RVC is zero-extended to 32 bits.
- inst_pc_o  out  PC_W  PC of inst_o.
- inst_is_comp_o  out  1  1 = inst_o is 16-bit (head[1:0] != 2'b11).
- count_o  out  $clog2(DEPTH_HW)+1  halfwords held.

Behaviour:
- Clocking: one clock `clk`, synchronous active-high reset `rst`. All state updates on the rising edge.
- Reset: count=0, read/write pointers=0, pc=RESET_PC, drop_lo=0. While rst=1: fetch_ready_o=0 and inst_valid_o=0. In the cycle after rst falls: fetch_ready_o=1 and inst_valid_o=0.
- Storage: circular array of DEPTH_HW halfwords. Pointers wrap modulo DEPTH_HW. count ranges 0..DEPTH_HW.
- Fetch accept:
  - fetch_ready_o = (count <= DEPTH_HW-2) && !flush_i && !rst. Computed from the registered count only; a same-cycle pop does not raise it.
  - A transfer occurs when fetch_valid_i && fetch_ready_o.
  - On transfer, push [15:0] then [31:16] (count += 2).
  - If drop_lo=1, push only [31:16] (count += 1) and clear drop_lo.
- Output (combinational from registered state; no bypass):
  - Let h0 = head halfword, h1 = next halfword.
  - If count>=1 and h0[1:0]!=2'b11: inst_valid_o=1, inst_o={16'h0,h0}, inst_is_comp_o=1.
  - Else if count>=2 and h0[1:0]==2'b11: inst_valid_o=1, inst_o={h1,h0}, inst_is_comp_o=0.
  - Otherwise inst_valid_o=0. A 32-bit instruction with only its lower half present waits for the next fetch.
  - inst_pc_o = pc register.
  - inst_valid_o is forced 0 while flush_i=1.
- Latency: a word accepted at edge N can produce inst_valid_o in cycle N+1.
- Pop: occurs when inst_valid_o && inst_ready_i.
  - 16-bit: head += 1, count -= 1, pc += 2.
  - 32-bit: head += 2, count -= 2, pc += 4.
  - PC arithmetic wraps modulo 2^PC_W.
- Simultaneous push and pop: both apply in the same edge; count = count + pushed - popped.
- Flush (priority over push and pop in the same cycle):
  - Next edge: count=0, pointers reset to 0.
  - pc = {flush_pc_i[PC_W-1:1],1'b0}.
  - drop_lo = flush_pc_i[1].
  - A fetch word presented during the flush cycle is not accepted.
  - Back-to-back flushes: the last one wins.
- Reset has priority over flush. Reset mid-stream discards all buffered halfwords, including a pending straddle.

Optional Feature:
- Macro: FETCH_ALIGN_ILLEGAL_CHECK_EN.
- Defined:
  - Adds output port inst_illegal_o (out, 1).
  - inst_illegal_o=1 when inst_valid_o=1, inst_is_comp_o=1 and h0==16'h0000; else 0. Reset value 0.
  - The instruction is still emitted and popped normally.
- Undefined: port absent; all-zero halfwords are emitted as ordinary 16-bit instructions.

Test Plan:
- Reset: hold rst 3 cycles, then release → fetch_ready_o=0 during reset; inst_valid_o=0 and count_o=0 throughout and after; inst_pc_o=RESET_PC.
- Two RVC instructions: push 32'h4501_4581 with inst_ready_i=1 → cycle N+1: inst_o=32'h0000_4581, pc=0, is_comp=1; cycle N+2: inst_o=32'h0000_4501, pc=2; then count_o=0.
- Straddle: push 32'h0513_4581, wait 2 cycles, push 32'h0001_0050 → 32'h0000_4581 at pc 0; inst_valid_o=0 until second word accepted; 32'h0050_0513 at pc 2, is_comp=0; then 32'h0000_0001 at pc 6.
- Halfword redirect: flush_i=1 with flush_pc_i=32'h102, then push 32'h4501_FFFF → single output 32'h0000_4501 at pc 32'h102; lower halfword dropped; count_o=0 after pop.
- Full/backpressure (DEPTH_HW=8): inst_ready_i=0, push 4 words → count_o=8, fetch_ready_o=0. Raise inst_ready_i in the same cycle as a fifth fetch_valid_i → fifth word not accepted that cycle; fetch_ready_o=1 the cycle after count_o falls to ≤6.
- Illegal (macro defined): push 32'h4581_0000 → inst_illegal_o=1 with inst_o=32'h0 at pc 0, then 0 for 32'h0000_4581 at pc 2. Macro undefined: same stream emitted, no illegal port.
